traffic_request_conditioner: RTL

//  Upstream front-end of the traffic controller: turns raw, asynchronous, bouncy lane

---
 rtl/traffic_request_conditioner_if.sv | 14 +
 rtl/traffic_request_conditioner.sv | 114 +++++++++++
 2 files changed

// File: rtl/traffic_request_conditioner_if.sv
// Lane-vector bundle between the detector front-end and the traffic controller.
// master: detector/controller side, slave: the conditioner.
interface traffic_request_conditioner_if #(
  parameter int LANES = 4
);
  logic [LANES-1:0] sensor_raw;
  logic [LANES-1:0] green;
  logic [LANES-1:0] traffic;
  logic [LANES-1:0] present;
  logic [LANES-1:0] starve;

  modport master (output sensor_raw, green, input traffic, present, starve);
  modport slave  (input sensor_raw, green, output traffic, present, starve);
endinterface

// File: rtl/traffic_request_conditioner.sv
// Traffic request conditioner: synchronizes and debounces raw lane detectors and
// turns them into sticky per-lane requests, released once the lane is served and empty.
// Optional build macro: STARVE_ALARM_EN adds per-lane wait counters and the starve alarm;
// without it starve is tied low and the port list is unchanged.

// One lane: sync chain, debounce, request latch and optional wait counter.
module traffic_request_lane #(
  parameter int DEBOUNCE = 4,
  parameter int HOLD_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic green,
  output logic traffic,
  output logic present,
  output logic starve
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous detector input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: accept a change only after DEBOUNCE consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      present <= 1'b0;
    end else if (s2 == present) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      cnt     <= '0;
      present <= s2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Sticky request: set on occupancy while not served, cleared once served and empty.
  always_ff @(posedge clk) begin
    if (rst)                     traffic <= 1'b0;
    else if (present && !green)  traffic <= 1'b1;
    else if (!present && green)  traffic <= 1'b0;
  end

`ifdef STARVE_ALARM_EN
  localparam int WW = $clog2(HOLD_MAX + 1);

  logic [WW-1:0] wait_cnt, wait_nxt;

  // Saturating count of cycles a pending request has gone unserved.
  always_comb begin
    wait_nxt = '0;
    if (traffic && !green)
      wait_nxt = (wait_cnt == WW'(HOLD_MAX)) ? wait_cnt : wait_cnt + WW'(1);
  end

  // Alarm is registered alongside the counter so it drops on the edge green is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      starve   <= (wait_nxt == WW'(HOLD_MAX));
    end
  end
`else
  assign starve = 1'b0;
`endif
endmodule

// Top: an array of independent lanes; arbitration is left to the controller.
module traffic_request_conditioner #(
  parameter int LANES    = 4,
  parameter int DEBOUNCE = 4,
  parameter int HOLD_MAX = 255
) (
  input logic clk,
  input logic rst,
  traffic_request_conditioner_if.slave bus
);
  logic [LANES-1:0] traffic_v, present_v, starve_v;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    traffic_request_lane #(
      .DEBOUNCE (DEBOUNCE),
      .HOLD_MAX (HOLD_MAX)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .raw     (bus.sensor_raw[i]),
      .green   (bus.green[i]),
      .traffic (traffic_v[i]),
      .present (present_v[i]),
      .starve  (starve_v[i])
    );
  end

  assign bus.traffic = traffic_v;
  assign bus.present = present_v;
  assign bus.starve  = starve_v;
endmodule
